// File: rtl/booth_pkg.sv
// Shared constants and FSM encoding for the Booth multiplier product path.
package booth_pkg;

  localparam int unsigned WORD_W = 5;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned PROD_W = 2 * WORD_W;

  typedef enum logic {
    WaitHi = 1'b0,
    WaitLo = 1'b1
  } state_e;

endpackage

// File: rtl/prod_fifo.sv
// Small circular product buffer with occupancy count; pointers wrap modulo Depth.
module prod_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [Width-1:0]             wdata_i,
  output logic [Width-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/product_collector.sv
// Pairs high/low Booth result words into full products and buffers them for a consumer.
module product_collector #(
  parameter int unsigned WORD_W = booth_pkg::WORD_W,
  parameter int unsigned DEPTH  = booth_pkg::DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WORD_W-1:0]            data_in,
  input  logic                         word_valid,
  input  logic                         abort,
  output logic                         in_ready,
  output logic [2*WORD_W-1:0]          prod,
  output logic                         prod_valid,
  input  logic                         prod_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         err
);

  import booth_pkg::*;

  localparam int unsigned ProdW = 2 * WORD_W;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] hi_q, hi_d;
  logic              err_q, err_d;
  logic              push, pop, accept, full, empty;
  logic [ProdW-1:0]  head;

  assign in_ready   = !full;
  assign prod_valid = !empty;
  assign prod       = empty ? '0 : head;
  assign pop        = prod_valid && prod_ready;
  assign err        = err_q;
  // Abort wins over a same-cycle word, so that word is neither taken nor counted as dropped.
  assign accept     = word_valid && in_ready && !abort;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    err_d   = err_q;
    push    = 1'b0;
    if (abort) begin
      state_d = WaitHi;
      hi_d    = '0;
    end else if (accept) begin
      unique case (state_q)
        WaitHi: begin
          hi_d    = data_in;
          state_d = WaitLo;
        end
        WaitLo: begin
          push    = 1'b1;
          state_d = WaitHi;
        end
        default: state_d = WaitHi;
      endcase
    end else if (word_valid) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WaitHi;
      hi_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
    end
  end

  prod_fifo #(
    .Width(ProdW),
    .Depth(DEPTH)
  ) u_prod_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i({hi_q, data_in}),
    .rdata_o(head),
    .full_o (full),
    .empty_o(empty),
    .count_o(count)
  );

endmodule

// File: tb/tb_product_collector.sv
// Bench for product_collector: queue-based reference model plus directed literal scenarios.
module tb_product_collector;

  localparam int W  = 5;
  localparam int D  = 2;
  localparam int CW = $clog2(D + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [W-1:0]    data_in = '0;
  logic            word_valid = 1'b0;
  logic            abort = 1'b0;
  logic            prod_ready = 1'b0;
  logic            in_ready;
  logic [2*W-1:0]  prod;
  logic            prod_valid;
  logic [CW-1:0]   count;
  logic            err;

  always #5 clk = ~clk;

  product_collector #(
    .WORD_W(W),
    .DEPTH (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .word_valid(word_valid),
    .abort     (abort),
    .in_ready  (in_ready),
    .prod      (prod),
    .prod_valid(prod_valid),
    .prod_ready(prod_ready),
    .count     (count),
    .err       (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: buffered products in order, plus whether a high half is held.
  logic [2*W-1:0] mq[$];
  bit             m_have_hi = 1'b0;
  logic [W-1:0]   m_hi = '0;
  bit             m_err = 1'b0;
  bit             m_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_have_hi = 1'b0;
      m_hi      = '0;
      m_err     = 1'b0;
      m_live    = 1'b1;
    end else if (m_live) begin
      automatic bit             room = mq.size() < D;
      automatic bit             take = (mq.size() > 0) && prod_ready;
      automatic bit             put  = 1'b0;
      automatic logic [2*W-1:0] p    = '0;
      if (abort) begin
        m_have_hi = 1'b0;
      end else if (word_valid && room) begin
        if (!m_have_hi) begin
          m_hi      = data_in;
          m_have_hi = 1'b1;
        end else begin
          p         = {m_hi, data_in};
          put       = 1'b1;
          m_have_hi = 1'b0;
        end
      end else if (word_valid) begin
        m_err = 1'b1;
      end
      if (take) void'(mq.pop_front());
      if (put) mq.push_back(p);
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("model in_ready", 32'(in_ready), 32'(mq.size() < D));
      check("model prod_valid", 32'(prod_valid), 32'(mq.size() > 0));
      check("model prod", 32'(prod), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
      check("model count", 32'(count), 32'(mq.size()));
      check("model err", 32'(err), 32'(m_err));
    end
  end

  task automatic drv(input int v, input int d, input int ab, input int pr);
    word_valid = (v != 0);
    data_in    = W'(d);
    abort      = (ab != 0);
    prod_ready = (pr != 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drv(0, 0, 0, 0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset count", 32'(count), 32'd0);
    check("reset prod_valid", 32'(prod_valid), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset prod", 32'(prod), 32'd0);

    // 3 x -2 = -6
    drv(1, 5'b11111, 0, 1); step();
    drv(1, 5'b11010, 0, 1); step();
    drv(0, 0, 0, 1);
    @(negedge clk);
    check("basic prod", 32'(prod), 32'h3FA);
    check("basic prod_valid", 32'(prod_valid), 32'd1);
    step();
    @(negedge clk);
    check("basic drained count", 32'(count), 32'd0);
    check("basic drained valid", 32'(prod_valid), 32'd0);

    // Backpressure: third pair is dropped entirely while full
    drv(1, 1, 0, 0); step();
    drv(1, 2, 0, 0); step();
    drv(1, 3, 0, 0); step();
    drv(1, 4, 0, 0); step();
    drv(1, 5, 0, 0); step();
    drv(1, 6, 0, 0); step();
    drv(0, 0, 0, 0);
    @(negedge clk);
    check("bp count", 32'(count), 32'd2);
    check("bp in_ready", 32'(in_ready), 32'd0);
    check("bp err", 32'(err), 32'd1);
    drv(0, 0, 0, 1);
    check("bp first", 32'(prod), 32'h022);
    step();
    @(negedge clk);
    check("bp second", 32'(prod), 32'h064);
    step();
    @(negedge clk);
    check("bp empty", 32'(count), 32'd0);
    drv(0, 0, 0, 0);

    // Abort discards held high half; word in abort cycle ignored
    drv(1, 5'b00001, 0, 0); step();
    drv(1, 5'b11111, 1, 0); step();
    drv(1, 5'b00000, 0, 0); step();
    drv(1, 5'b00110, 0, 0); step();
    drv(0, 0, 0, 0);
    @(negedge clk);
    check("abort prod", 32'(prod), 32'h006);
    check("abort count", 32'(count), 32'd1);

    // Push and pop together
    drv(1, 5'b00111, 0, 0); step();
    drv(1, 5'b01000, 0, 1); step();
    drv(0, 0, 0, 0);
    @(negedge clk);
    check("pushpop count", 32'(count), 32'd1);
    check("pushpop head", 32'(prod), 32'h0E8);

    // Reset while full with err set
    drv(1, 9, 0, 0); step();
    drv(1, 10, 0, 0); step();
    drv(1, 11, 0, 0); step();
    drv(0, 0, 0, 0);
    @(negedge clk);
    check("full count", 32'(count), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst full count", 32'(count), 32'd0);
    check("rst full valid", 32'(prod_valid), 32'd0);
    check("rst full err", 32'(err), 32'd0);
    check("rst full in_ready", 32'(in_ready), 32'd1);

    // Reset mid-pair: next word must be treated as a high half
    drv(1, 5'b00001, 0, 0); step();
    rst = 1'b1;
    drv(1, 5'b00010, 0, 0); step();
    rst = 1'b0;
    drv(1, 5'b00011, 0, 0); step();
    drv(0, 0, 0, 0);
    @(negedge clk);
    check("rst pair count", 32'(count), 32'd0);
    drv(1, 5'b00100, 0, 0); step();
    drv(0, 0, 0, 0);
    @(negedge clk);
    check("rst pair prod", 32'(prod), 32'h064);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      drv(int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 15) == 0), int'($urandom_range(0, 1)));
      step();
    end
    rst = 1'b0;
    drv(0, 0, 0, 0);
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
